alu_result_buffer: RTL and testbench

Downstream stage of the 2-bit-opcode ALU (ADD/SUB/AND/OR, registered result of WIDTH+1 bits, one-cycle latency). It tracks which cycles issued a real operation and captures the matching ALU result one cycle later. Each captured result is stored with its opcode and derived zero/carry flags in a small first-word-fall-through FIFO. A valid/ready interface presents results to the consumer (writeback/scoreboard).

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_result_buffer_if.sv | 38 +++
 rtl/alu_res_fifo.sv | 66 ++++++
 rtl/alu_result_buffer.sv | 93 +++++++++
 tb/tb_alu_result_buffer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and result-buffer entry layout.
package alu_pkg;

  localparam logic [1:0] FUN_ADD = 2'b00;
  localparam logic [1:0] FUN_SUB = 2'b01;
  localparam logic [1:0] FUN_AND = 2'b10;
  localparam logic [1:0] FUN_OR  = 2'b11;

  localparam int unsigned ALU_WIDTH = 16;

  // Entry layout, MSB to LSB: {fun[1:0], data[WIDTH-1:0], carry, zero}
  localparam int unsigned ENTRY_W = 2 + ALU_WIDTH + 1 + 1;

  // Entry width for an arbitrary operand width
  function automatic int unsigned entry_w(input int unsigned width);
    return 2 + width + 1 + 1;
  endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// Issue/result/consumer bundle between the ALU pipeline, the result buffer and its consumer.
interface alu_result_buffer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             ISSUE_VALID;
  logic [1:0]       ISSUE_FUN;
  logic [WIDTH:0]   ALU_OUT;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_CARRY;
  logic             OUT_ZERO;
  logic [1:0]       OUT_FUN;
  logic             FULL;
  logic             EMPTY;
  logic [CW-1:0]    COUNT;
  logic [CNTW-1:0]  DROP_CNT;
  logic             OVERFLOW;

  // Issue side and consumer
  modport master (
    output ISSUE_VALID, ISSUE_FUN, ALU_OUT, OUT_READY,
    input  OUT_VALID, OUT_DATA, OUT_CARRY, OUT_ZERO, OUT_FUN,
           FULL, EMPTY, COUNT, DROP_CNT, OVERFLOW
  );

  // Result buffer
  modport slave (
    input  ISSUE_VALID, ISSUE_FUN, ALU_OUT, OUT_READY,
    output OUT_VALID, OUT_DATA, OUT_CARRY, OUT_ZERO, OUT_FUN,
           FULL, EMPTY, COUNT, DROP_CNT, OVERFLOW
  );

endinterface

// File: rtl/alu_res_fifo.sv
// Generic synchronous first-word-fall-through FIFO; occupancy tracked by a counter.
module alu_res_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_wr_c, do_rd_c;

  // Qualify requests: no read when empty, no write when full unless a read frees a slot
  always_comb begin
    do_rd_c = rd_en && (count_q != '0);
    do_wr_c = wr_en && ((count_q != CW'(DEPTH)) || do_rd_c);
  end

  // Next-state pointers (DEPTH is a power of two, so natural wrap) and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_rd_c) rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_wr_c && !do_rd_c)      count_d = count_q + CW'(1);
    else if (!do_wr_c && do_rd_c) count_d = count_q - CW'(1);
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_wr_c) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/alu_result_buffer.sv
// Captures the ALU result one cycle after each issued operation, derives flags and
// queues {fun, data, carry, zero} for a valid/ready consumer; counts overflow drops.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 8
) (
  input  logic CLK,
  input  logic RST,
  alu_result_buffer_if.slave bus
);

  localparam int unsigned EW = entry_w(WIDTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0] DROP_MAX = '1;

  logic            pend_v_q, pend_v_d;
  logic [1:0]      pend_fun_q, pend_fun_d;
  logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;
  logic            overflow_q, overflow_d;

  logic            pop_c, wr_en_c, drop_c, wr_zero_c;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   rd_entry;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full, fifo_empty;

  // Write/pop/drop decisions and entry packing for the result arriving this cycle
  always_comb begin
    pop_c     = !fifo_empty && bus.OUT_READY;
    wr_en_c   = pend_v_q && (!fifo_full || pop_c);
    drop_c    = pend_v_q && fifo_full && !pop_c;
    wr_zero_c = (bus.ALU_OUT[WIDTH-1:0] == '0);
    wr_entry  = {pend_fun_q, bus.ALU_OUT[WIDTH-1:0], bus.ALU_OUT[WIDTH], wr_zero_c};
  end

  // Next state for pending stage and drop bookkeeping
  always_comb begin
    pend_v_d   = bus.ISSUE_VALID;
    pend_fun_d = bus.ISSUE_FUN;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + CNTW'(1);
    end
  end

  // Pending-stage and drop registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend_v_q   <= 1'b0;
      pend_fun_q <= 2'b00;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      pend_v_q   <= pend_v_d;
      pend_fun_q <= pend_fun_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  alu_res_fifo #(
    .DATA_W (EW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .wr_en   (wr_en_c),
    .wr_data (wr_entry),
    .rd_en   (pop_c),
    .rd_data (rd_entry),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head-entry unpack, forced to zero while empty
  assign bus.OUT_VALID = !fifo_empty;
  assign bus.OUT_FUN   = fifo_empty ? 2'b00      : rd_entry[EW-1 -: 2];
  assign bus.OUT_DATA  = fifo_empty ? WIDTH'(0)  : rd_entry[EW-3 -: WIDTH];
  assign bus.OUT_CARRY = fifo_empty ? 1'b0       : rd_entry[1];
  assign bus.OUT_ZERO  = fifo_empty ? 1'b0       : rd_entry[0];
  assign bus.FULL      = fifo_full;
  assign bus.EMPTY     = fifo_empty;
  assign bus.COUNT     = fifo_count;
  assign bus.DROP_CNT  = drop_cnt_q;
  assign bus.OVERFLOW  = overflow_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized + directed bench for alu_result_buffer against a queue-based reference model.
module tb_alu_result_buffer;
  import alu_pkg::*;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNTW  = 8;
  localparam int unsigned MASK  = (1 << W) - 1;
  localparam int unsigned DMAX  = (1 << CNTW) - 1;

  typedef struct packed {
    logic [1:0]   fun;
    logic [W-1:0] data;
    logic         carry;
    logic         zero;
  } entry_t;

  logic CLK;
  logic RST;

  alu_result_buffer_if #(.WIDTH(W), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();

  alu_result_buffer #(.WIDTH(W), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  entry_t      mq[$];
  logic        m_pend_v;
  entry_t      m_pend;
  int unsigned m_drop;
  logic        m_ovf;
  logic [W:0]  alu_next;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected entry from operands, straight from the opcode semantics
  function automatic entry_t ref_entry(input logic [1:0] fun, input int unsigned a, input int unsigned b);
    entry_t e;
    int unsigned r;
    e.fun   = fun;
    e.carry = 1'b0;
    case (fun)
      FUN_ADD: begin r = a + b; e.carry = (r > MASK); end
      FUN_SUB: begin r = a - b; e.carry = (a < b);    end
      FUN_AND: r = a & b;
      default: r = a | b;
    endcase
    e.data = W'(r & MASK);
    e.zero = (r & MASK) == 0;
    return e;
  endfunction

  // The upstream ALU: WIDTH+1-bit registered result
  function automatic logic [W:0] alu_model(input logic [1:0] fun, input int unsigned a, input int unsigned b);
    logic [W:0] x, y;
    x = (W+1)'(a);
    y = (W+1)'(b);
    case (fun)
      FUN_ADD: return x + y;
      FUN_SUB: return x - y;
      FUN_AND: return x & y;
      default: return x | y;
    endcase
  endfunction

  function automatic int unsigned pick_operand();
    case ($urandom % 4)
      0:       return 0;
      1:       return MASK;
      default: return $urandom & MASK;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pend_v = 1'b0;
    m_pend   = '0;
    m_drop   = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic check_outputs(input string ph);
    entry_t h;
    logic   ev;
    ev = (mq.size() != 0);
    h  = ev ? mq[0] : '0;
    check({ph, ".valid"},    32'(bus.OUT_VALID), 32'(ev));
    check({ph, ".data"},     32'(bus.OUT_DATA),  32'(h.data));
    check({ph, ".carry"},    32'(bus.OUT_CARRY), 32'(h.carry));
    check({ph, ".zero"},     32'(bus.OUT_ZERO),  32'(h.zero));
    check({ph, ".fun"},      32'(bus.OUT_FUN),   32'(h.fun));
    check({ph, ".count"},    32'(bus.COUNT),     32'(mq.size()));
    check({ph, ".full"},     32'(bus.FULL),      32'(mq.size() == DEPTH));
    check({ph, ".empty"},    32'(bus.EMPTY),     32'(mq.size() == 0));
    check({ph, ".drop_cnt"}, 32'(bus.DROP_CNT),  32'(m_drop));
    check({ph, ".overflow"}, 32'(bus.OVERFLOW),  32'(m_ovf));
  endtask

  // One clock: drive at negedge, advance model, check 1 time unit after posedge
  task automatic cycle(input string ph, input logic v, input logic [1:0] fun,
                       input int unsigned a, input int unsigned b, input logic rdy);
    logic pop;
    bus.ISSUE_VALID = v;
    bus.ISSUE_FUN   = fun;
    bus.ALU_OUT     = alu_next;
    bus.OUT_READY   = rdy;
    pop = (mq.size() != 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (m_pend_v) begin
      if (mq.size() < DEPTH) mq.push_back(m_pend);
      else begin
        m_ovf = 1'b1;
        if (m_drop < DMAX) m_drop++;
      end
    end
    m_pend_v = v;
    m_pend   = ref_entry(fun, a, b);
    @(posedge CLK);
    alu_next = v ? alu_model(fun, a, b) : (W+1)'($urandom);
    #1;
    check_outputs(ph);
    @(negedge CLK);
  endtask

  task automatic drain(input string ph);
    for (int i = 0; i < DEPTH + 2; i++) cycle(ph, 1'b0, 2'b00, 0, 0, 1'b1);
  endtask

  initial begin
    CLK = 1'b0;
    RST = 1'b0;
    bus.ISSUE_VALID = 1'b0;
    bus.ISSUE_FUN   = 2'b00;
    bus.ALU_OUT     = '0;
    bus.OUT_READY   = 1'b0;
    alu_next        = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check_outputs("reset");

    // ADD with carry-out and zero data
    cycle("add", 1'b1, FUN_ADD, 16'hFFFF, 16'h0001, 1'b0);
    check("add.lat1", 32'(bus.OUT_VALID), 32'd0);
    cycle("add", 1'b0, FUN_ADD, 0, 0, 1'b0);
    check("add.lat2", 32'(bus.OUT_VALID), 32'd1);
    check("add.data_c", {15'd0, bus.OUT_CARRY, bus.OUT_DATA}, 32'h10000);
    drain("add_drain");

    // SUB with borrow, then AND
    cycle("sub", 1'b1, FUN_SUB, 3, 5, 1'b1);
    cycle("and", 1'b1, FUN_AND, 16'h0FF0, 16'h00FF, 1'b1);
    check("sub.data", 32'(bus.OUT_DATA), 32'hFFFE);
    check("sub.carry", 32'(bus.OUT_CARRY), 32'd1);
    cycle("and", 1'b0, FUN_ADD, 0, 0, 1'b1);
    check("and.data", 32'(bus.OUT_DATA), 32'h00F0);
    drain("sub_drain");

    // Fill and overflow, then drain in order
    for (int i = 1; i <= 5; i++) cycle("fill", 1'b1, FUN_OR, i, 0, 1'b0);
    cycle("fill", 1'b0, FUN_ADD, 0, 0, 1'b0);
    check("fill.drop1", 32'(bus.DROP_CNT), 32'd1);
    check("fill.count4", 32'(bus.COUNT), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      check("fill.order", 32'(bus.OUT_DATA), 32'(i));
      cycle("drain", 1'b0, FUN_ADD, 0, 0, 1'b1);
    end
    check("drain.empty", 32'(bus.EMPTY), 32'd1);

    // Full with simultaneous pop as the fifth result lands
    for (int i = 1; i <= 5; i++) cycle("fullpop", 1'b1, FUN_ADD, 16'h100 + i, 0, 1'b0);
    cycle("fullpop", 1'b0, FUN_ADD, 0, 0, 1'b1);
    check("fullpop.count", 32'(bus.COUNT), 32'd4);
    check("fullpop.head", 32'(bus.OUT_DATA), 32'h102);
    drain("fullpop_drain");

    // Streaming with consumer always ready
    for (int i = 0; i < 20; i++) begin
      cycle("stream", 1'b1, FUN_ADD, i, 0, 1'b1);
      check("stream.count_le1", 32'(bus.COUNT <= 1), 32'd1);
    end
    drain("stream_drain");

    // Async reset with COUNT=3 and a result pending
    for (int i = 0; i < 4; i++) cycle("prerst", 1'b1, FUN_SUB, 10 + i, 1, 1'b0);
    check("prerst.count", 32'(bus.COUNT), 32'd3);
    #2;
    RST = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    bus.ISSUE_VALID = 1'b0;
    cycle("post_rst", 1'b0, FUN_ADD, 0, 0, 1'b0);
    cycle("post_rst", 1'b1, FUN_AND, 16'hAAAA, 16'hFFFF, 1'b0);
    cycle("post_rst", 1'b0, FUN_ADD, 0, 0, 1'b0);
    check("post_rst.data", 32'(bus.OUT_DATA), 32'hAAAA);
    drain("post_rst_drain");

    // Random traffic
    for (int i = 0; i < 600; i++)
      cycle("rand", 1'($urandom % 4 != 0), 2'($urandom), pick_operand(), pick_operand(),
            1'($urandom % 3 != 0));

    // Drop counter saturation
    for (int i = 0; i < 280; i++) cycle("sat", 1'b1, FUN_OR, i & MASK, 0, 1'b0);
    check("sat.drop", 32'(bus.DROP_CNT), 32'(DMAX));
    drain("sat_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
